// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the banked register file.
// Defaults match what the CPU top instantiates.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } copy_state_e;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;

endpackage

// File: rtl/banked_register_file_if.sv
// Register-file access and context-swap bus.
// The master is decode/writeback/interrupt control; the slave is the register file.
interface banked_register_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              save_req;
  logic              restore_req;
  logic              busy;
  logic              done;
  logic              shadow_valid;

  modport master (
    output write_enable, write_addr, write_data, read_addr1, read_addr2,
           save_req, restore_req,
    input  read_data1, read_data2, busy, done, shadow_valid
  );

  modport slave (
    input  write_enable, write_addr, write_data, read_addr1, read_addr2,
           save_req, restore_req,
    output read_data1, read_data2, busy, done, shadow_valid
  );
endinterface

// File: rtl/bank_copy_seq.sv
// SAVE/RESTORE sequencer: walks one register per cycle between main and shadow banks.
// It also owns the shadow_valid flag, since only this sequencer changes it.
module bank_copy_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req_i,
  input  logic              restore_req_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              shadow_valid_o,
  output logic              copy_save_o,
  output logic              copy_restore_o,
  output logic [ADDR_W-1:0] idx_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  copy_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic              sv_q, sv_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    sv_d    = sv_q;
    unique case (state_q)
      IDLE: begin
        // SAVE has priority; a RESTORE with no snapshot is silently ignored
        if (save_req_i) begin
          state_d = SAVE;
          idx_d   = '0;
          sv_d    = 1'b0;
        end else if (restore_req_i && sv_q) begin
          state_d = RESTORE;
          idx_d   = '0;
        end
      end
      SAVE: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
          sv_d    = 1'b1;
        end
      end
      RESTORE: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign shadow_valid_o = sv_q;
  assign copy_save_o    = (state_q == SAVE);
  assign copy_restore_o = (state_q == RESTORE);
  assign idx_o          = idx_q;

endmodule

// File: rtl/banked_register_file.sv
// General-purpose register file: two async read ports, one sync write port,
// and a shadow bank for interrupt context save/restore.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic                  clk,
  input logic                  reset,
  banked_register_file_if.slave bus
);

  logic [DATA_W-1:0] regs_q   [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  logic              copy_save;
  logic              copy_restore;
  logic [ADDR_W-1:0] idx;
  logic              wr_eff;
  logic              restore_skip;

  bank_copy_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_seq (
    .clk            (clk),
    .reset          (reset),
    .save_req_i     (bus.save_req),
    .restore_req_i  (bus.restore_req),
    .busy_o         (bus.busy),
    .done_o         (bus.done),
    .shadow_valid_o (bus.shadow_valid),
    .copy_save_o    (copy_save),
    .copy_restore_o (copy_restore),
    .idx_o          (idx)
  );

  // Writes are dropped outright during RESTORE so they cannot race the copy
  assign wr_eff = bus.write_enable && !copy_restore &&
                  !((ZERO_REG != 0) && (bus.write_addr == '0));
  assign restore_skip = (ZERO_REG != 0) && (idx == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      if (copy_save) shadow_q[idx] <= regs_q[idx];
      if (copy_restore && !restore_skip) regs_q[idx] <= shadow_q[idx];
      if (wr_eff) regs_q[bus.write_addr] <= bus.write_data;
    end
  end

  always_comb begin
    bus.read_data1 = regs_q[bus.read_addr1];
    if ((ZERO_REG != 0) && (bus.read_addr1 == '0))
      bus.read_data1 = '0;
    else if ((BYPASS != 0) && wr_eff && (bus.write_addr == bus.read_addr1))
      bus.read_data1 = bus.write_data;
  end

  always_comb begin
    bus.read_data2 = regs_q[bus.read_addr2];
    if ((ZERO_REG != 0) && (bus.read_addr2 == '0))
      bus.read_data2 = '0;
    else if ((BYPASS != 0) && wr_eff && (bus.write_addr == bus.read_addr2))
      bus.read_data2 = bus.write_data;
  end

endmodule
